// File: rtl/program_loader.sv
// program_loader: byte-stream loader that fills instruction memory at boot.
// Stream format: 32-bit little-endian word count N, then N little-endian
// 32-bit words written to word addresses 0..N-1. done releases the core.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN -- adds one trailing
// checksum byte (XOR of all data bytes) verified before done is raised.
// Handshake: rx_valid is a one-cycle strobe per byte with no backpressure;
// every strobe is consumed. imem_write_enable is a one-cycle write strobe and
// imem_address/imem_write_data are valid with it and hold otherwise.
// The FSM state is visible to checkers as the enum register state_q.
module program_loader #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  imem_write_enable,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [31:0]           imem_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  length_error,
  output logic                  checksum_error
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERROR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    S_CSUM,
    S_CSUM_ERR
`endif
  } state_e;

  // Largest legal word count; held one bit wider than the count itself.
  localparam logic [32:0]         CAPACITY = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] WORD_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q;
  logic [1:0]            byte_cnt_q;
  logic [23:0]           shift_q;       // first three bytes of the current word
  logic [ADDR_WIDTH:0]   word_cnt_q;    // one extra bit so N = capacity does not wrap
  logic [ADDR_WIDTH:0]   word_total_q;
  logic [31:0]           word_d;        // word completed by the byte on rx_data
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  assign word_d = {rx_data, shift_q};

  // Loader FSM: byte assembly, length decode, memory writes and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_LEN;
      byte_cnt_q        <= 2'd0;
      shift_q           <= 24'd0;
      word_cnt_q        <= '0;
      word_total_q      <= '0;
      imem_write_enable <= 1'b0;
      imem_address      <= '0;
      imem_write_data   <= 32'd0;
      busy              <= 1'b0;
      done              <= 1'b0;
      length_error      <= 1'b0;
      checksum_error    <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q            <= 8'd0;
`endif
    end else begin
      imem_write_enable <= 1'b0;
      // busy follows the state; terminal transitions below override it.
      busy <= (state_q == S_LEN) || (state_q == S_DATA)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              || (state_q == S_CSUM)
`endif
              ;
      case (state_q)
        S_LEN: begin
          if (rx_valid) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0: shift_q[7:0]   <= rx_data;
              2'd1: shift_q[15:8]  <= rx_data;
              2'd2: shift_q[23:16] <= rx_data;
              default: begin
                word_total_q <= word_d[ADDR_WIDTH:0];
                if (word_d == 32'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  state_q <= S_CSUM;
`else
                  state_q <= S_DONE;
                  done    <= 1'b1;
                  busy    <= 1'b0;
`endif
                end else if ({1'b0, word_d} > CAPACITY) begin
                  state_q      <= S_ERROR;
                  length_error <= 1'b1;
                  busy         <= 1'b0;
                end else begin
                  state_q <= S_DATA;
                end
              end
            endcase
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ rx_data;
`endif
            case (byte_cnt_q)
              2'd0: shift_q[7:0]   <= rx_data;
              2'd1: shift_q[15:8]  <= rx_data;
              2'd2: shift_q[23:16] <= rx_data;
              default: begin
                imem_write_enable <= 1'b1;
                imem_address      <= word_cnt_q[ADDR_WIDTH-1:0];
                imem_write_data   <= word_d;
                word_cnt_q        <= word_cnt_q + WORD_ONE;
                if (word_cnt_q == word_total_q - WORD_ONE) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  state_q <= S_CSUM;
`else
                  // done rises one cycle later, after the final write strobe.
                  state_q <= S_DONE;
                  busy    <= 1'b0;
`endif
                end
              end
            endcase
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (rx_valid) begin
            busy <= 1'b0;
            if (rx_data == csum_q) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_q        <= S_CSUM_ERR;
              checksum_error <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          done <= 1'b1;
        end
        default: begin
          // Terminal error states ignore all bytes until reset.
        end
      endcase
    end
  end

endmodule
